// File: rtl/harvos_mmu_pkg.sv
// Shared MMU definitions: satp field layout, CSR op encoding, satp FSM states
// and the WARL legalisation used by the satp CSR owner.
package harvos_mmu_pkg;

    localparam int unsigned SATP_MODE_BIT = 31;
    localparam int unsigned SATP_ASID_HI  = 30;
    localparam int unsigned SATP_ASID_LO  = 22;
    localparam int unsigned SATP_PPN_HI   = 21;
    localparam int unsigned SATP_PPN_LO   = 0;

    localparam logic SATP_MODE_SV32 = 1'b1;

    typedef enum logic [1:0] {
        CSR_READ = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    typedef enum logic {
        SATP_IDLE  = 1'b0,
        SATP_FLUSH = 1'b1
    } satp_state_e;

    // MODE is pinned to Sv32; unimplemented ASID/PPN bits read as zero.
    function automatic logic [31:0] satp_legalise(input logic [31:0]  raw,
                                                  input int unsigned asid_w,
                                                  input int unsigned ppn_w);
        logic [31:0] asid_mask;
        logic [31:0] ppn_mask;
        asid_mask = ((32'h1 << asid_w) - 32'h1) << SATP_ASID_LO;
        ppn_mask  = ((32'h1 << ppn_w) - 32'h1) << SATP_PPN_LO;
        return (32'(SATP_MODE_SV32) << SATP_MODE_BIT) | (raw & (asid_mask | ppn_mask));
    endfunction

endpackage

// File: rtl/harvos_satp_csr.sv
// Owner of the RV32 satp CSR: WARL legalisation to Sv32, TLB-flush handshake
// on every value change, and Bare-mode write attempt reporting.
module harvos_satp_csr
    import harvos_mmu_pkg::*;
#(
    parameter int unsigned ASID_W    = 9,
    parameter int unsigned PPN_W     = 22,
    parameter logic [21:0] RESET_PPN = 22'h0,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             csr_valid_i,
    output logic             csr_ready_o,
    input  logic [1:0]       csr_op_i,
    input  logic [31:0]      csr_wdata_i,
    output logic [31:0]      csr_rdata_o,
    output logic [31:0]      csr_satp_q,
    output logic             flush_req_o,
    input  logic             flush_ack_i,
    output logic             bare_attempt_o,
    output logic [CNT_W-1:0] bare_count_o
);

    localparam logic [31:0] SATP_RESET =
        satp_legalise({SATP_MODE_SV32, 9'h0, RESET_PPN}, ASID_W, PPN_W);

    // MODE is not stored: it is a constant 1, so it holds even while in reset.
    logic [30:0]      satp_q, satp_d;
    satp_state_e      state_q, state_d;
    logic             bare_q, bare_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    csr_op_e     op;
    logic [31:0] old_satp;
    logic [31:0] raw;
    logic [31:0] legal;
    logic        accept;
    logic        is_write;

    assign op       = csr_op_e'(csr_op_i);
    assign old_satp = {SATP_MODE_SV32, satp_q};
    assign accept   = csr_valid_i & csr_ready_o;
    assign is_write = (op != CSR_READ);

    always_comb begin
        raw = old_satp;
        unique case (op)
            CSR_READ: raw = old_satp;
            CSR_RW:   raw = csr_wdata_i;
            CSR_RS:   raw = old_satp | csr_wdata_i;
            CSR_RC:   raw = old_satp & ~csr_wdata_i;
            default:  raw = old_satp;
        endcase
        legal = satp_legalise(raw, ASID_W, PPN_W);
    end

    always_comb begin
        satp_d  = satp_q;
        state_d = state_q;
        bare_d  = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            SATP_IDLE: begin
                if (accept) begin
                    if (is_write && !raw[SATP_MODE_BIT]) begin
                        bare_d = 1'b1;
                        if (!(&cnt_q)) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    if (legal != old_satp) begin
                        satp_d  = legal[30:0];
                        state_d = SATP_FLUSH;
                    end
                end
            end
            SATP_FLUSH: begin
                if (flush_ack_i) begin
                    state_d = SATP_IDLE;
                end
            end
            default: state_d = SATP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            satp_q  <= SATP_RESET[30:0];
            state_q <= SATP_IDLE;
            bare_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            satp_q  <= satp_d;
            state_q <= state_d;
            bare_q  <= bare_d;
            cnt_q   <= cnt_d;
        end
    end

    assign csr_ready_o    = (state_q == SATP_IDLE);
    assign flush_req_o    = (state_q == SATP_FLUSH);
    assign csr_rdata_o    = old_satp;
    assign csr_satp_q     = old_satp;
    assign bare_attempt_o = bare_q;
    assign bare_count_o   = cnt_q;

endmodule

// File: tb/tb_harvos_satp_csr.sv
// Scoreboarded bench for harvos_satp_csr: a default instance and one with
// ASID_W=4 / CNT_W=2, each driven through the same request task.
module tb_harvos_satp_csr;

    typedef struct {
        logic [31:0] satp;
        logic        bare;
        logic [31:0] cnt;
        logic        flush;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v1, v2, ack1, ack2;
    logic [1:0]  op;
    logic [31:0] wd;

    logic        rdy1, fl1, ba1, rdy2, fl2, ba2;
    logic [31:0] rdata1, satp1, rdata2, satp2;
    logic [7:0]  cnt1;
    logic [1:0]  cnt2;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] m_satp [2];
    logic [31:0] m_cnt  [2];
    exp_t        sb [$];

    always #5 clk = ~clk;

    harvos_satp_csr u_dut (
        .clk(clk), .rst_n(rst_n), .csr_valid_i(v1), .csr_ready_o(rdy1),
        .csr_op_i(op), .csr_wdata_i(wd), .csr_rdata_o(rdata1), .csr_satp_q(satp1),
        .flush_req_o(fl1), .flush_ack_i(ack1), .bare_attempt_o(ba1), .bare_count_o(cnt1)
    );

    harvos_satp_csr #(.ASID_W(4), .CNT_W(2)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .csr_valid_i(v2), .csr_ready_o(rdy2),
        .csr_op_i(op), .csr_wdata_i(wd), .csr_rdata_o(rdata2), .csr_satp_q(satp2),
        .flush_req_o(fl2), .flush_ack_i(ack2), .bare_attempt_o(ba2), .bare_count_o(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic sample(input int s, output logic rdy, output logic [31:0] rd,
                          output logic [31:0] st, output logic fl, output logic ba,
                          output logic [31:0] cnt);
        if (s == 0) begin
            rdy = rdy1; rd = rdata1; st = satp1; fl = fl1; ba = ba1; cnt = {24'h0, cnt1};
        end else begin
            rdy = rdy2; rd = rdata2; st = satp2; fl = fl2; ba = ba2; cnt = {30'h0, cnt2};
        end
    endtask

    function automatic logic [31:0] model_legal(input int s, input logic [31:0] r);
        logic [31:0] res;
        int          asid_bits;
        asid_bits = (s == 0) ? 9 : 4;
        res = 32'h8000_0000;
        for (int i = 0; i < 22; i++) res[i] = r[i];
        for (int i = 0; i < asid_bits; i++) res[22+i] = r[22+i];
        return res;
    endfunction

    task automatic reset_models();
        m_satp[0] = 32'h8000_0000; m_satp[1] = 32'h8000_0000;
        m_cnt[0]  = 0;             m_cnt[1]  = 0;
    endtask

    // One CSR request on instance s; ack raised ack_dly cycles into FLUSH.
    task automatic req(input int s, input logic [1:0] o, input logic [31:0] w, input int ack_dly);
        exp_t        e;
        logic [31:0] raw, old, rd, st, cnt, cmax;
        logic        rdy, fl, ba;
        @(negedge clk);
        op = o; wd = w;
        if (s == 0) v1 = 1'b1; else v2 = 1'b1;
        #1;
        sample(s, rdy, rd, st, fl, ba, cnt);
        chk("ready_on_accept", {31'h0, rdy}, 32'h1);
        chk("rdata_pre_write", rd, m_satp[s]);
        old = m_satp[s];
        case (o)
            2'b00:   raw = old;
            2'b01:   raw = w;
            2'b10:   raw = old | w;
            default: raw = old & ~w;
        endcase
        cmax    = (s == 0) ? 32'd255 : 32'd3;
        e.bare  = (o != 2'b00) && (raw[31] == 1'b0);
        if (e.bare && m_cnt[s] < cmax) m_cnt[s] = m_cnt[s] + 1;
        e.satp  = model_legal(s, raw);
        e.flush = (e.satp != old);
        e.cnt   = m_cnt[s];
        m_satp[s] = e.satp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        v1 = 1'b0; v2 = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        sample(s, rdy, rd, st, fl, ba, cnt);
        chk("satp_after_write", st, e.satp);
        chk("bare_pulse", {31'h0, ba}, {31'h0, e.bare});
        chk("bare_count", cnt, e.cnt);
        chk("flush_req_rise", {31'h0, fl}, {31'h0, e.flush});
        chk("ready_after_accept", {31'h0, rdy}, {31'h0, ~e.flush});
        if (e.flush) begin
            for (int i = 0; i < ack_dly; i++) begin
                @(negedge clk);
                sample(s, rdy, rd, st, fl, ba, cnt);
                chk("flush_hold", {31'h0, fl}, 32'h1);
                chk("ready_low_in_flush", {31'h0, rdy}, 32'h0);
            end
            if (s == 0) ack1 = 1'b1; else ack2 = 1'b1;
            @(posedge clk);
            #1;
            ack1 = 1'b0; ack2 = 1'b0;
        end
        @(negedge clk);
        sample(s, rdy, rd, st, fl, ba, cnt);
        chk("flush_done", {31'h0, fl}, 32'h0);
        chk("ready_back", {31'h0, rdy}, 32'h1);
        chk("bare_single_cycle", {31'h0, ba}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b1; v1 = 1'b0; v2 = 1'b0; ack1 = 1'b0; ack2 = 1'b0;
        op = 2'b00; wd = 32'h0;
        reset_models();
        #2 rst_n = 1'b0;
        #1;
        chk("mode_in_reset", {31'h0, satp1[31]}, 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_satp", satp1, 32'h8000_0000);
        chk("rst_flush", {31'h0, fl1}, 32'h0);
        chk("rst_ready", {31'h0, rdy1}, 32'h1);
        chk("rst_bare", {31'h0, ba1}, 32'h0);
        chk("rst_count", {24'h0, cnt1}, 32'h0);
        chk("rst_satp_small", satp2, 32'h8000_0000);

        req(0, 2'b01, 32'h8040_1234, 3);
        req(0, 2'b01, 32'h0000_0055, 1);
        chk("bare_write_value", satp1, 32'h8000_0055);
        req(0, 2'b01, 32'h8000_0000, 0);
        req(0, 2'b11, 32'h8000_0000, 0);
        req(0, 2'b00, 32'h1234_5678, 0);
        req(0, 2'b10, 32'h0012_0003, 0);
        req(0, 2'b11, 32'h0000_0002, 2);
        chk("count_after_seq", {24'h0, cnt1}, 32'h2);

        // Ack while idle must not disturb anything.
        @(negedge clk);
        ack1 = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("stray_ack_flush", {31'h0, fl1}, 32'h0);
            chk("stray_ack_ready", {31'h0, rdy1}, 32'h1);
        end
        ack1 = 1'b0;

        // Reset asserted in the middle of a flush.
        @(negedge clk);
        op = 2'b01; wd = 32'h8000_1111; v1 = 1'b1;
        @(posedge clk);
        #1 v1 = 1'b0;
        @(negedge clk);
        chk("midflush_req", {31'h0, fl1}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_flush", {31'h0, fl1}, 32'h0);
        chk("async_rst_satp", satp1, 32'h8000_0000);
        chk("async_rst_count", {24'h0, cnt1}, 32'h0);
        chk("async_rst_ready", {31'h0, rdy1}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        reset_models();

        req(1, 2'b01, 32'hFFFF_FFFF, 2);
        chk("asid4_legalise", satp2, 32'h83FF_FFFF);
        for (int i = 0; i < 5; i++) req(1, 2'b01, 32'h0000_0055, 0);
        chk("count_saturates", {30'h0, cnt2}, 32'h3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
